// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM state encoding,
// default expected ID/timestamp words and a small compare helper.
package soc_sysid_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TMO_W   = 8;
   localparam int unsigned RETRY_W = 2;

   localparam logic [DATA_W-1:0] DEF_EXPECTED_ID = 32'h0000_0000;
   localparam logic [DATA_W-1:0] DEF_EXPECTED_TS = 32'h6946_BC94;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_ID = 3'd1,
      ST_RD_TS = 3'd2,
      ST_GAP   = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } sysid_state_e;

   // Both captured words must equal their expected values.
   function automatic logic words_match(
      input logic [DATA_W-1:0] id_word,
      input logic [DATA_W-1:0] ts_word,
      input logic [DATA_W-1:0] exp_id,
      input logic [DATA_W-1:0] exp_ts
   );
      return (id_word == exp_id) && (ts_word == exp_ts);
   endfunction

endpackage

// File: rtl/soc_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM, compares them with the
// expected build values and retries the whole sequence on a stalled-read timeout.
module soc_sysid_checker
   import soc_sysid_pkg::*;
#(
   parameter logic [DATA_W-1:0]  EXPECTED_ID    = DEF_EXPECTED_ID,
   parameter logic [DATA_W-1:0]  EXPECTED_TS    = DEF_EXPECTED_TS,
   parameter logic [TMO_W-1:0]   TIMEOUT_CYCLES = TMO_W'(255),
   parameter logic [RETRY_W-1:0] MAX_RETRIES    = RETRY_W'(3)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   output logic               avm_address,
   output logic               avm_read,
   input  logic [DATA_W-1:0]  avm_readdata,
   input  logic               avm_waitrequest,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic               timeout_err,
   output logic [RETRY_W-1:0] retry_count,
   output logic [DATA_W-1:0]  captured_id,
   output logic [DATA_W-1:0]  captured_ts
);

   sysid_state_e       r_state;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic               r_avm_address;
   logic               r_avm_read;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic               r_timeout_err;
   logic [RETRY_W-1:0] r_retry_count;
   logic [DATA_W-1:0]  r_captured_id;
   logic [DATA_W-1:0]  r_captured_ts;

   logic w_accept;
   logic w_tmo_hit;
   logic w_retry_left;

   // An accepted read wins over a counter that reaches the limit in the same cycle.
   assign w_accept     = !avm_waitrequest;
   assign w_tmo_hit    = (r_tmo_cnt == TIMEOUT_CYCLES);
   assign w_retry_left = (r_retry_count < MAX_RETRIES);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_tmo_cnt     <= '0;
         r_avm_address <= 1'b0;
         r_avm_read    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_retry_count <= '0;
         r_captured_id <= '0;
         r_captured_ts <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state       <= ST_RD_ID;
                  r_avm_read    <= 1'b1;
                  r_avm_address <= 1'b0;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_pass        <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_retry_count <= '0;
                  r_tmo_cnt     <= '0;
               end
            end

            ST_RD_ID, ST_RD_TS: begin
               if (w_accept) begin
                  r_tmo_cnt <= '0;
                  if (r_state == ST_RD_ID) begin
                     r_captured_id <= avm_readdata;
                     r_avm_address <= 1'b1;
                     r_state       <= ST_RD_TS;
                  end else begin
                     r_captured_ts <= avm_readdata;
                     r_avm_read    <= 1'b0;
                     r_avm_address <= 1'b0;
                     r_state       <= ST_CHECK;
                  end
               end else if (w_tmo_hit) begin
                  // Abandon this attempt; either back off for one cycle or give up.
                  r_tmo_cnt     <= '0;
                  r_avm_read    <= 1'b0;
                  r_avm_address <= 1'b0;
                  if (w_retry_left) begin
                     r_retry_count <= r_retry_count + RETRY_W'(1);
                     r_state       <= ST_GAP;
                  end else begin
                     r_timeout_err <= 1'b1;
                     r_pass        <= 1'b0;
                     r_busy        <= 1'b0;
                     r_done        <= 1'b1;
                     r_state       <= ST_DONE;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end

            ST_GAP: begin
               r_avm_read    <= 1'b1;
               r_avm_address <= 1'b0;
               r_state       <= ST_RD_ID;
            end

            ST_CHECK: begin
               r_pass  <= words_match(r_captured_id, r_captured_ts, EXPECTED_ID, EXPECTED_TS);
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end

            default: begin
               r_avm_read    <= 1'b0;
               r_avm_address <= 1'b0;
               r_busy        <= 1'b0;
               r_done        <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign avm_address = r_avm_address;
   assign avm_read    = r_avm_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign timeout_err = r_timeout_err;
   assign retry_count = r_retry_count;
   assign captured_id = r_captured_id;
   assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Bench: two checker instances (default limits and a 4-cycle timeout) behind a
// scripted sysid slave; outcomes are predicted from per-read stall lengths.
module tb_soc_sysid_checker;

   logic        clock;
   logic        reset_n;
   logic        start_a, start_b;
   logic        sel;
   logic        wreq;
   logic [31:0] slv_id, slv_ts;
   logic [31:0] readdata;
   logic        wait_a, wait_b;

   logic        a_addr, a_read, a_busy, a_done, a_pass, a_terr;
   logic [1:0]  a_retry;
   logic [31:0] a_cid, a_cts;
   logic        b_addr, b_read, b_busy, b_done, b_pass, b_terr;
   logic [1:0]  b_retry;
   logic [31:0] b_cid, b_cts;

   logic        c_addr, c_read, c_busy, c_done, c_pass, c_terr;
   logic [1:0]  c_retry;
   logic [31:0] c_cid, c_cts;

   int total = 0;
   int bad   = 0;

   int unsigned stall_q[$];
   int unsigned plan_q[$];
   int unsigned rem;
   bit          need_load;
   logic        last_read, last_wreq;
   int          att_cnt, acc_cnt;
   logic [31:0] m_cid[2];
   logic [31:0] m_cts[2];

   soc_sysid_checker u_a (
      .clock(clock), .reset_n(reset_n), .start(start_a),
      .avm_address(a_addr), .avm_read(a_read), .avm_readdata(readdata),
      .avm_waitrequest(wait_a), .busy(a_busy), .done(a_done), .pass(a_pass),
      .timeout_err(a_terr), .retry_count(a_retry), .captured_id(a_cid), .captured_ts(a_cts)
   );

   soc_sysid_checker #(.TIMEOUT_CYCLES(8'd4), .MAX_RETRIES(2'd3)) u_b (
      .clock(clock), .reset_n(reset_n), .start(start_b),
      .avm_address(b_addr), .avm_read(b_read), .avm_readdata(readdata),
      .avm_waitrequest(wait_b), .busy(b_busy), .done(b_done), .pass(b_pass),
      .timeout_err(b_terr), .retry_count(b_retry), .captured_id(b_cid), .captured_ts(b_cts)
   );

   assign c_addr  = sel ? b_addr  : a_addr;
   assign c_read  = sel ? b_read  : a_read;
   assign c_busy  = sel ? b_busy  : a_busy;
   assign c_done  = sel ? b_done  : a_done;
   assign c_pass  = sel ? b_pass  : a_pass;
   assign c_terr  = sel ? b_terr  : a_terr;
   assign c_retry = sel ? b_retry : a_retry;
   assign c_cid   = sel ? b_cid   : a_cid;
   assign c_cts   = sel ? b_cts   : a_cts;

   assign readdata = c_addr ? slv_ts : slv_id;
   assign wait_a   = sel ? 1'b1 : wreq;
   assign wait_b   = sel ? wreq : 1'b1;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish before 90000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // Slave: each new read request holds waitrequest high for the next planned stall length.
   initial begin
      wreq = 1'b0; rem = 0; need_load = 1'b1; last_read = 1'b0; last_wreq = 1'b0;
      att_cnt = 0; acc_cnt = 0;
      forever begin
         @(negedge clock);
         if (last_read && !last_wreq) begin
            acc_cnt++;
            need_load = 1'b1;
         end else if (last_read && last_wreq && rem > 0) begin
            rem--;
         end
         if (!c_read) need_load = 1'b1;
         if (c_read && !last_read) att_cnt++;
         if (c_read && need_load) begin
            rem = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
            need_load = 1'b0;
         end
         wreq = c_read && (rem != 0);
         last_read = c_read;
         last_wreq = wreq;
      end
   end

   // Predicts the outcome from the stall plan, then runs one sequence and checks it.
   task automatic run_seq(input logic which, input int unsigned tmo, input logic [31:0] id_v,
                          input logic [31:0] ts_v, input bit mid_start, input string tag);
      int unsigned m[$];
      int unsigned s;
      int          exp_cyc, exp_ret, exp_att, exp_acc, cyc;
      bit          exp_pass, exp_terr, fin, to, pulsed;
      logic [31:0] ecid, ects;
      m = plan_q;
      exp_cyc = 1; exp_ret = 0; exp_att = 0; exp_acc = 0;
      exp_pass = 1'b0; exp_terr = 1'b0; fin = 1'b0;
      ecid = m_cid[which]; ects = m_cts[which];
      while (!fin) begin
         exp_att++;
         to = 1'b0;
         s = (m.size() > 0) ? m.pop_front() : 0;
         if (s > tmo) begin
            exp_cyc += int'(tmo) + 1; to = 1'b1;
         end else begin
            exp_cyc += int'(s) + 1; ecid = id_v; exp_acc++;
            s = (m.size() > 0) ? m.pop_front() : 0;
            if (s > tmo) begin
               exp_cyc += int'(tmo) + 1; to = 1'b1;
            end else begin
               exp_cyc += int'(s) + 1; ects = ts_v; exp_acc++;
            end
         end
         if (!to) begin
            exp_cyc += 1;
            exp_pass = (ecid == 32'h0000_0000) && (ects == 32'h6946_BC94);
            fin = 1'b1;
         end else if (exp_ret < 3) begin
            exp_ret++;
            exp_cyc += 1;
         end else begin
            exp_terr = 1'b1;
            fin = 1'b1;
         end
      end

      stall_q = plan_q;
      slv_id = id_v; slv_ts = ts_v; sel = which;
      att_cnt = 0; acc_cnt = 0;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      step();
      start_a = 1'b0; start_b = 1'b0;
      cyc = 1; pulsed = 1'b0;
      chk({tag, "_busy_c1"}, 32'(c_busy), 32'd1);
      chk({tag, "_read_c1"}, 32'(c_read), 32'd1);
      while (!c_done && cyc < 5000) begin
         if (mid_start && !pulsed && c_addr) begin
            if (which) start_b = 1'b1; else start_a = 1'b1;
            pulsed = 1'b1;
         end
         step();
         start_a = 1'b0; start_b = 1'b0;
         cyc++;
      end
      chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_pass"}, 32'(c_pass), 32'(exp_pass));
      chk({tag, "_terr"}, 32'(c_terr), 32'(exp_terr));
      chk({tag, "_retry"}, 32'(c_retry), 32'(exp_ret));
      chk({tag, "_cid"}, c_cid, ecid);
      chk({tag, "_cts"}, c_cts, ects);
      chk({tag, "_attempts"}, 32'(att_cnt), 32'(exp_att));
      chk({tag, "_accepted"}, 32'(acc_cnt), 32'(exp_acc));
      chk({tag, "_busy_done"}, 32'(c_busy), 32'd0);
      chk({tag, "_read_done"}, 32'(c_read), 32'd0);
      repeat (3) step();
      chk({tag, "_hold_done"}, 32'(c_done), 32'd1);
      chk({tag, "_hold_pass"}, 32'(c_pass), 32'(exp_pass));
      m_cid[which] = ecid;
      m_cts[which] = ects;
   endtask

   initial begin
      int k;
      sel = 1'b0; start_a = 1'b0; start_b = 1'b0; reset_n = 1'b0;
      slv_id = '0; slv_ts = '0;
      m_cid[0] = '0; m_cid[1] = '0; m_cts[0] = '0; m_cts[1] = '0;
      repeat (3) step();
      chk("rst_read", 32'(a_read | b_read), 32'd0);
      chk("rst_busy", 32'(a_busy | b_busy), 32'd0);
      chk("rst_done", 32'(a_done | b_done), 32'd0);
      chk("rst_cid", a_cid | b_cid, 32'd0);
      reset_n = 1'b1;
      repeat (4) step();
      chk("idle_busy", 32'(a_busy | b_busy), 32'd0);
      chk("idle_read", 32'(a_read | b_read), 32'd0);

      plan_q = {};
      run_seq(1'b0, 255, 32'h0000_0000, 32'h6946_BC94, 1'b0, "min_pass");
      run_seq(1'b0, 255, 32'h0000_0000, 32'h6946_BC95, 1'b0, "ts_mismatch");
      plan_q = {300, 43, 0};
      run_seq(1'b0, 255, 32'h0000_0000, 32'h6946_BC94, 1'b0, "stall300");
      plan_q = {1000, 1000, 1000, 1000};
      run_seq(1'b1, 4, 32'h0000_0000, 32'h6946_BC94, 1'b0, "stuck");
      plan_q = {4, 4};
      run_seq(1'b1, 4, 32'h0000_0000, 32'h6946_BC94, 1'b0, "edge_accept");
      plan_q = {0, 5, 2, 0};
      run_seq(1'b1, 4, 32'h0000_0000, 32'h6946_BC94, 1'b0, "edge_timeout");
      plan_q = {0, 5};
      run_seq(1'b0, 255, 32'h0000_0000, 32'h6946_BC94, 1'b1, "mid_start");

      // Reset while the timestamp read is stalled.
      stall_q = {0, 1000};
      slv_id = 32'hDEAD_BEEF; slv_ts = 32'h6946_BC94; sel = 1'b0;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      k = 0;
      while (!a_addr && k < 20) begin
         step();
         k++;
      end
      chk("rst_mid_reached_ts", 32'(a_addr), 32'd1);
      repeat (3) step();
      chk("rst_mid_cid", a_cid, 32'hDEAD_BEEF);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_read", 32'(a_read), 32'd0);
      chk("rst_mid_addr", 32'(a_addr), 32'd0);
      chk("rst_mid_busy", 32'(a_busy), 32'd0);
      chk("rst_mid_flags", 32'({a_done, a_pass, a_terr, a_retry}), 32'd0);
      chk("rst_mid_cid0", a_cid, 32'd0);
      chk("rst_mid_cts0", a_cts, 32'd0);
      repeat (2) step();
      stall_q.delete();
      m_cid[0] = '0; m_cid[1] = '0; m_cts[0] = '0; m_cts[1] = '0;
      reset_n = 1'b1;
      repeat (5) step();
      chk("post_rst_idle", 32'({a_busy, a_read, a_done}), 32'd0);
      plan_q = {};
      run_seq(1'b0, 255, 32'h0000_0000, 32'h6946_BC94, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         logic        which;
         int unsigned tmo;
         logic [31:0] idv, tsv;
         which = (i % 4 != 0);
         tmo = which ? 4 : 255;
         plan_q.delete();
         for (int j = 0; j < 8; j++) begin
            if (which)
               plan_q.push_back(($urandom_range(0, 9) > 6) ? $urandom_range(5, 9) : $urandom_range(0, 4));
            else
               plan_q.push_back($urandom_range(0, 20));
         end
         idv = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_0000;
         tsv = ($urandom_range(0, 3) == 0) ? $urandom : 32'h6946_BC94;
         run_seq(which, tmo, idv, tsv, ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/soc_sysid_checker.md
SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, system ID value required at sysid address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h6946_BC94, build timestamp required at sysid address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255 (8-bit), maximum waitrequest-stalled cycles per read.
REQ-004 SHALL have parameter MAX_RETRIES, default 3 (2-bit), whole-sequence retries after a timeout.
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to run a check sequence.
REQ-008 avm_address  out  1  sysid word select: 0 = ID, 1 = timestamp.
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_readdata  in  32  sysid read data; valid when avm_read=1 and avm_waitrequest=0 (zero latency).
REQ-011 avm_waitrequest  in  1  slave stall.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 done  out  1  high while in DONE.
REQ-014 pass  out  1  high in DONE when both words matched and no timeout occurred.
REQ-015 timeout_err  out  1  high in DONE when retries were exhausted.
REQ-016 retry_count  out  2  retries used in the current or last sequence.
REQ-017 captured_id, captured_ts  out  32 each  last words read.

Function
REQ-018 FSM states SHALL be IDLE, RD_ID, RD_TS, GAP, CHECK, DONE.
REQ-019 IDLE/DONE + start=1 -> RD_ID next cycle; the entry SHALL clear retry_count, pass, timeout_err and the timeout counter.
REQ-020 start SHALL be ignored in RD_ID, RD_TS, GAP and CHECK.
REQ-021 RD_ID SHALL drive avm_read=1 and avm_address=0; on waitrequest=0 it SHALL capture captured_id and go to RD_TS.
REQ-022 RD_TS SHALL drive avm_read=1 and avm_address=1; on waitrequest=0 it SHALL capture captured_ts and go to CHECK.
REQ-023 Minimum sequence: start at cycle 0, RD_ID at cycle 1, RD_TS at cycle 2, CHECK at cycle 3, done=1 from cycle 4.
REQ-024 The 8-bit timeout counter SHALL increment on each stalled read cycle and clear on each accepted read.
REQ-025 Timeout SHALL fire when the counter equals TIMEOUT_CYCLES with waitrequest still 1.
REQ-026 On timeout with retry_count<MAX_RETRIES: increment retry_count, go to GAP; GAP drives avm_read=0 for one cycle, then goes to RD_ID.
REQ-027 On timeout with retry_count=MAX_RETRIES: timeout_err=1, pass=0, go to DONE.
REQ-028 CHECK SHALL set pass=(captured_id==EXPECTED_ID)&&(captured_ts==EXPECTED_TS) and go to DONE.
REQ-029 CHECK SHALL hold avm_read=0.
REQ-030 A data mismatch SHALL NOT trigger a retry.
REQ-031 avm_read SHALL be 0 in IDLE, GAP, CHECK and DONE.
REQ-032 avm_address SHALL be 0 outside RD_TS.
REQ-033 DONE SHALL hold all results until the next start.
REQ-034 Simultaneous waitrequest falling and timeout count reached SHALL treat the read as accepted; no timeout.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE.
REQ-036 reset_n=0 SHALL immediately force avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout_err=0, retry_count=0, captured_id=0, captured_ts=0 and timeout counter=0, including mid-read.
REQ-037 After reset release the block SHALL stay in IDLE until start.

Structure
REQ-038 State encoding and the default EXPECTED_ID/EXPECTED_TS constants SHALL live in shared package soc_sysid_pkg.
REQ-039 Implementation SHALL be a single module with no sub-modules; the timeout counter stays inline.

Verification
REQ-040 Bench with waitrequest=0, ID=0, TS=0x6946BC94, start -> done at cycle 4, pass=1, retry_count=0.
REQ-041 Bench returns TS=0x6946BC95 -> done, pass=0, timeout_err=0, captured_ts=0x6946BC95, exactly two reads issued.
REQ-042 waitrequest=1 for the first 300 cycles of the first RD_ID, then 0 -> one GAP, retry_count=1, pass=1.
REQ-043 waitrequest stuck at 1 with TIMEOUT_CYCLES=4, MAX_RETRIES=3 -> 4 read attempts, then timeout_err=1, pass=0, retry_count=3.
REQ-044 reset_n=0 during RD_TS stall -> avm_read=0 without waiting for a clock edge, all outputs 0; a later start gives a clean pass.
REQ-045 start pulsed during RD_TS -> ignored, exactly one sequence of two reads completes.
